// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection and pipeline-register control with stall/flush/halt FSM
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000,
  parameter int          CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      PCResult,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchTarget,
  input  logic             Jump,
  input  logic [31:0]      JumpTarget,
  input  logic             LoadUseHazard,
  input  logic             StallReq,
  input  logic [2:0]       StallCycles,
  input  logic             Halt,
  output logic [31:0]      Address,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] StallCount
);
  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10, HALTED = 2'b11} state_t;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  assign State = state;
  // next state, stall counter and pipeline controls, in priority order
  always_comb begin
    Address    = PCResult + 32'd4;
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = state == FLUSH;
    IDEXBubble = 1'b0;
    state_n    = RUN;
    cnt_n      = cnt;
    if (!Reset) begin
      Address   = RESET_VECTOR;
      IFIDWrite = 1'b0;
      IFIDFlush = 1'b1;
      cnt_n     = 3'd0;
    end else if (state == HALTED || Halt) begin
      Address   = PCResult;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IFIDFlush = 1'b0;
      state_n   = HALTED;
    end else if (state == STALL) begin
      Address    = PCResult;
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IFIDFlush  = 1'b0;
      IDEXBubble = 1'b1;
      cnt_n      = cnt - 3'd1;
      state_n    = cnt == 3'd1 ? RUN : STALL;
    end else if (BranchTaken) begin
      Address    = {BranchTarget[31:2], 2'b00};
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
      state_n    = FLUSH;
    end else if (Jump) begin
      Address   = {JumpTarget[31:2], 2'b00};
      IFIDFlush = 1'b1;
    end else if (LoadUseHazard || (StallReq && StallCycles != 3'd0)) begin
      Address    = PCResult;
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
      if (!LoadUseHazard && StallCycles > 3'd1) begin
        cnt_n   = StallCycles - 3'd1;
        state_n = STALL;
      end
    end
  end
  // state register, stall countdown and saturating stall performance counter
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= RUN;
      cnt        <= 3'd0;
      StallCount <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (!PCWrite && state != HALTED && StallCount != '1)
        StallCount <= StallCount + CNT_W'(1);
    end
  end
endmodule
